// File: rtl/laser_rx_drain.sv
// Laser receiver byte-pair FIFO draining to an FTDI 245 async FIFO, one byte per write strobe.
// Optional build macro LASER_RX_DRAIN_MARKER_EN prefixes every entry with an 8'hA5 marker byte.
module laser_rx_drain #(
    parameter int DEPTH       = 16,
    parameter int SETUP_CYC   = 1,
    parameter int STROBE_CYC  = 3,
    parameter int RECOVER_CYC = 3
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     data_valid,
    input  logic [7:0]               data1_in,
    input  logic [7:0]               data2_in,
    input  logic                     ftdi_txe_n,
    input  logic                     clear_overflow,
    output logic [7:0]               ftdi_data,
    output logic                     ftdi_oe,
    output logic                     ftdi_wr_n,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     empty,
    output logic                     overflow
);
    localparam int AW   = $clog2(DEPTH);
    localparam int MAXC = (SETUP_CYC > STROBE_CYC) ?
                          ((SETUP_CYC > RECOVER_CYC) ? SETUP_CYC : RECOVER_CYC) :
                          ((STROBE_CYC > RECOVER_CYC) ? STROBE_CYC : RECOVER_CYC);
    localparam int CW   = $clog2(MAXC) + 1;
`ifdef LASER_RX_DRAIN_MARKER_EN
    localparam int SW = 2;
    localparam int NBYTES = 3;
`else
    localparam int SW = 1;
    localparam int NBYTES = 2;
`endif
    localparam logic [SW-1:0] LAST_SEL = SW'(NBYTES - 1);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SETUP   = 3'd1;
    localparam logic [2:0] S_STROBE  = 3'd2;
    localparam logic [2:0] S_HOLD    = 3'd3;
    localparam logic [2:0] S_RECOVER = 3'd4;

    logic          dv_q, txe_meta_q, txe_s_q, ovf_q;
    logic [15:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] sel_q, sel_d;
    logic [7:0]    data_q, data_d, head_byte;
    logic          oe_q, oe_d, wr_n_q, wr_n_d;
    logic          push, pop, full, accept, drop, empty_w;
    logic [15:0]   head;

    assign push    = data_valid & ~dv_q;
    assign full    = (count_q == FULL_CNT);
    assign empty_w = (count_q == '0);
    assign accept  = push & (~full | pop);
    assign drop    = push & full & ~pop;
    assign head    = mem_q[rd_ptr_q];

`ifdef LASER_RX_DRAIN_MARKER_EN
    always_comb begin
        case (sel_q)
            2'd0:    head_byte = 8'hA5;
            2'd1:    head_byte = head[15:8];
            default: head_byte = head[7:0];
        endcase
    end
`else
    assign head_byte = sel_q[0] ? head[7:0] : head[15:8];
`endif

    // Drain sequencer; txe is only consulted in IDLE so a started byte always completes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        data_d  = data_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty_w && !txe_s_q) begin
                    data_d  = head_byte;
                    state_d = S_SETUP;
                    cnt_d   = '0;
                end
            end
            S_SETUP: begin
                if (cnt_q == CW'(SETUP_CYC - 1)) begin
                    state_d = S_STROBE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STROBE: begin
                if (cnt_q == CW'(STROBE_CYC - 1)) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HOLD: begin
                pop     = (sel_q == LAST_SEL);
                sel_d   = (sel_q == LAST_SEL) ? '0 : sel_q + 1'b1;
                state_d = S_RECOVER;
                cnt_d   = '0;
            end
            S_RECOVER: begin
                if (cnt_q == CW'(RECOVER_CYC - 1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        oe_d   = (state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_HOLD);
        wr_n_d = (state_d != S_STROBE);
    end

    always_comb begin
        count_d = count_q;
        case ({accept, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (accept) mem_q[wr_ptr_q] <= {data1_in, data2_in};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dv_q       <= 1'b0;
            txe_meta_q <= 1'b1;
            txe_s_q    <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            sel_q      <= '0;
            data_q     <= 8'h00;
            oe_q       <= 1'b0;
            wr_n_q     <= 1'b1;
        end else begin
            dv_q       <= data_valid;
            txe_meta_q <= ftdi_txe_n;
            txe_s_q    <= txe_meta_q;
            if (accept) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)    rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q    <= count_d;
            // A drop on the same edge as a clear leaves the flag set.
            if (drop)                ovf_q <= 1'b1;
            else if (clear_overflow) ovf_q <= 1'b0;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sel_q      <= sel_d;
            data_q     <= data_d;
            oe_q       <= oe_d;
            wr_n_q     <= wr_n_d;
        end
    end

    assign ftdi_data  = data_q;
    assign ftdi_oe    = oe_q;
    assign ftdi_wr_n  = wr_n_q;
    assign fifo_count = count_q;
    assign empty      = empty_w;
    assign overflow   = ovf_q;
endmodule

// File: tb/tb_laser_rx_drain.sv
// Bench for laser_rx_drain: edge-scheduled reference model, directed scenarios and random traffic.
module tb_laser_rx_drain;
    localparam int DEPTH = 16;
    localparam int S     = 1;
    localparam int ST    = 3;
    localparam int R     = 3;
    localparam int PER   = S + ST + R + 2;
`ifdef LASER_RX_DRAIN_MARKER_EN
    localparam int NB = 3;
`else
    localparam int NB = 2;
`endif

    logic       clock = 1'b0, reset_n = 1'b1, data_valid = 1'b0;
    logic       ftdi_txe_n = 1'b1, clear_overflow = 1'b0;
    logic [7:0] data1_in = 8'h00, data2_in = 8'h00;
    logic [7:0] ftdi_data;
    logic       ftdi_oe, ftdi_wr_n, empty, overflow;
    logic [4:0] fifo_count;

    laser_rx_drain #(.DEPTH(DEPTH), .SETUP_CYC(S), .STROBE_CYC(ST), .RECOVER_CYC(R)) dut (
        .clock(clock), .reset_n(reset_n), .data_valid(data_valid),
        .data1_in(data1_in), .data2_in(data2_in), .ftdi_txe_n(ftdi_txe_n),
        .clear_overflow(clear_overflow), .ftdi_data(ftdi_data), .ftdi_oe(ftdi_oe),
        .ftdi_wr_n(ftdi_wr_n), .fifo_count(fifo_count), .empty(empty), .overflow(overflow)
    );

    always #5 clock = ~clock;

    int n_cmp = 0, n_bad = 0;
    int k = 0;
    // Model state: FIFO as a queue plus the absolute edge at which the current byte started.
    logic [15:0] q[$];
    int   cur_st = -1000, next_ok = 0, pend_edge = -1, bidx = 0;
    bit   pend_last = 1'b0;
    logic m_dvq = 1'b0, m_ovf = 1'b0, t1 = 1'b1, t2 = 1'b1;
    logic [7:0] m_data = 8'h00;
    logic prev_wr = 1'b1;
    logic [7:0] log_data[$];
    int   log_edge[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @edge %0d: got %0h, expected %0h", nm, k, act, exp);
        end
    endtask

    function automatic logic [7:0] sel_byte(input logic [15:0] e, input int i);
        if (NB == 3) return (i == 0) ? 8'hA5 : ((i == 1) ? e[15:8] : e[7:0]);
        return (i == 0) ? e[15:8] : e[7:0];
    endfunction

    task automatic model_reset();
        q.delete();
        cur_st = -1000; next_ok = 0; pend_edge = -1; pend_last = 1'b0; bidx = 0;
        m_dvq = 1'b0; m_ovf = 1'b0; t1 = 1'b1; t2 = 1'b1; m_data = 8'h00;
    endtask

    task automatic model_edge();
        int sz;
        bit pop, push;
        sz  = q.size();
        pop = 1'b0;
        if (k == pend_edge) begin
            pop  = pend_last;
            bidx = (bidx + 1) % NB;
        end
        if (k >= next_ok && sz != 0 && t2 == 1'b0) begin
            cur_st    = k;
            next_ok   = k + PER;
            pend_edge = k + S + ST + 1;
            pend_last = (bidx == NB - 1);
            m_data    = sel_byte(q[0], bidx);
        end
        if (pop) void'(q.pop_front());
        push  = data_valid && !m_dvq;
        m_dvq = data_valid;
        if (push && sz == DEPTH && !pop) m_ovf = 1'b1;
        else begin
            if (push) q.push_back({data1_in, data2_in});
            if (clear_overflow) m_ovf = 1'b0;
        end
        t2 = t1;
        t1 = ftdi_txe_n;
    endtask

    // Compare process: model step then full output check, 2 time units after every rising edge.
    initial begin
        logic e_oe, e_wr;
        forever begin
            @(posedge clock);
            #2;
            k++;
            if (!reset_n) model_reset();
            else model_edge();
            e_oe = (k >= cur_st) && (k <= cur_st + S + ST);
            e_wr = !((k >= cur_st + S) && (k < cur_st + S + ST));
            chk("wr_n", ftdi_wr_n, e_wr);
            chk("oe", ftdi_oe, e_oe);
            chk("data", ftdi_data, m_data);
            chk("count", fifo_count, q.size());
            chk("empty", empty, q.size() == 0);
            chk("overflow", overflow, m_ovf);
            if (prev_wr && !ftdi_wr_n) begin
                log_data.push_back(ftdi_data);
                log_edge.push_back(k);
            end
            prev_wr = ftdi_wr_n;
        end
    end

    task automatic pulse(input logic [7:0] a, input logic [7:0] b, output int pe);
        @(negedge clock);
        data1_in = a; data2_in = b; data_valid = 1'b1;
        pe = k + 1;
        @(negedge clock);
        data_valid = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic expect_stream(input string nm, input int base, input logic [15:0] pr[$]);
        logic [7:0] ex[$];
        foreach (pr[i]) begin
            if (NB == 3) ex.push_back(8'hA5);
            ex.push_back(pr[i][15:8]);
            ex.push_back(pr[i][7:0]);
        end
        chk({nm, "_len"}, log_data.size() - base, ex.size());
        foreach (ex[i])
            if (base + i < log_data.size()) chk($sformatf("%s_b%0d", nm, i), log_data[base + i], ex[i]);
    endtask

    task automatic wait_strobe(input string nm);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clock);
            if (!ftdi_wr_n) found = 1'b1;
        end
        chk(nm, found, 1'b1);
    endtask

    initial begin
        int pe, base, mode;
        logic [15:0] pr[$];
        #2 reset_n = 1'b0;
        #1;
        chk("rst_wr_n", ftdi_wr_n, 1'b1);
        chk("rst_oe", ftdi_oe, 1'b0);
        chk("rst_data", ftdi_data, 8'h00);
        chk("rst_count", fifo_count, 0);
        chk("rst_empty", empty, 1'b1);
        chk("rst_ovf", overflow, 1'b0);
        wait_cyc(3);
        ftdi_txe_n = 1'b0;
        reset_n = 1'b1;
        wait_cyc(4);

        // Single pair: latency, spacing and bytes.
        base = log_data.size();
        pulse(8'hC8, 8'h77, pe);
        wait_cyc(12 * NB);
        pr = '{16'hC877};
        expect_stream("single", base, pr);
        if (log_edge.size() >= base + 2) begin
            chk("first_fall_lat", log_edge[base] - pe, 2);
            chk("byte_period", log_edge[base + 1] - log_edge[base], 9);
        end
        chk("single_empty", empty, 1'b1);

        base = log_data.size();
        pulse(8'h12, 8'h34, pe);
        wait_cyc(12 * NB);
        pr = '{16'h1234};
        expect_stream("pair_1234", base, pr);

        // Back-pressure.
        ftdi_txe_n = 1'b1;
        wait_cyc(3);
        base = log_data.size();
        pulse(8'h12, 8'h34, pe);
        pulse(8'h56, 8'h78, pe);
        pulse(8'h9A, 8'hBC, pe);
        wait_cyc(10);
        chk("bp_count", fifo_count, 3);
        chk("bp_wr_n", ftdi_wr_n, 1'b1);
        chk("bp_nobytes", log_data.size() - base, 0);
        ftdi_txe_n = 1'b0;
        wait_cyc(3 * NB * 9 + 10);
        pr = '{16'h1234, 16'h5678, 16'h9ABC};
        expect_stream("bp", base, pr);

        // Overflow, clear, and clear-with-drop priority.
        ftdi_txe_n = 1'b1;
        wait_cyc(3);
        base = log_data.size();
        pr.delete();
        for (int i = 0; i < DEPTH + 2; i++) begin
            pulse(8'h10 + 8'(i), 8'hE0 - 8'(i), pe);
            if (i < DEPTH) pr.push_back({8'h10 + 8'(i), 8'hE0 - 8'(i)});
        end
        wait_cyc(2);
        chk("ovf_count", fifo_count, 16);
        chk("ovf_flag", overflow, 1'b1);
        @(negedge clock) clear_overflow = 1'b1;
        @(negedge clock) clear_overflow = 1'b0;
        chk("ovf_cleared", overflow, 1'b0);
        @(negedge clock);
        data1_in = 8'hEE; data2_in = 8'hEE; data_valid = 1'b1; clear_overflow = 1'b1;
        @(negedge clock);
        data_valid = 1'b0; clear_overflow = 1'b0;
        chk("ovf_priority", overflow, 1'b1);
        @(negedge clock) clear_overflow = 1'b1;
        @(negedge clock) clear_overflow = 1'b0;
        ftdi_txe_n = 1'b0;
        wait_cyc(DEPTH * NB * 9 + 20);
        expect_stream("ovf_drain", base, pr);

        // Commitment: txe rises during the first strobe.
        base = log_data.size();
        pulse(8'h3C, 8'hC3, pe);
        wait_strobe("commit_strobe_seen");
        ftdi_txe_n = 1'b1;
        wait_cyc(30);
        chk("commit_one_byte", log_data.size() - base, 1);
        chk("commit_count", fifo_count, 1);
        ftdi_txe_n = 1'b0;
        wait_cyc(12 * NB);
        pr = '{16'h3CC3};
        expect_stream("commit", base, pr);

        // Level-held data_valid.
        ftdi_txe_n = 1'b1;
        wait_cyc(3);
        @(negedge clock);
        data1_in = 8'h44; data2_in = 8'h55; data_valid = 1'b1;
        wait_cyc(50);
        data_valid = 1'b0;
        wait_cyc(2);
        chk("level_one_push", fifo_count, 1);
        ftdi_txe_n = 1'b0;
        wait_cyc(12 * NB);

        // Asynchronous reset while wr_n is low.
        pulse(8'h5A, 8'hA5, pe);
        wait_strobe("rst_strobe_seen");
        #1 reset_n = 1'b0;
        #1;
        chk("midrst_wr_n", ftdi_wr_n, 1'b1);
        chk("midrst_oe", ftdi_oe, 1'b0);
        chk("midrst_count", fifo_count, 0);
        @(negedge clock) reset_n = 1'b1;
        wait_cyc(4);

        // Random traffic with shifting back-pressure regimes.
        mode = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            if (c % 150 == 0) mode = int'($urandom_range(0, 2));
            case (mode)
                0:       ftdi_txe_n = 1'b0;
                1:       ftdi_txe_n = 1'b1;
                default: if ($urandom_range(0, 7) == 0) ftdi_txe_n = ~ftdi_txe_n;
            endcase
            if ($urandom_range(0, 3) == 0) data_valid = ~data_valid;
            data1_in = 8'($urandom);
            data2_in = 8'($urandom);
            clear_overflow = ($urandom_range(0, 39) == 0);
        end
        @(negedge clock);
        data_valid = 1'b0; clear_overflow = 1'b0; ftdi_txe_n = 1'b0;
        wait_cyc(DEPTH * NB * 9 + 40);
        chk("final_empty", empty, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/laser_rx_drain.md
# laser_rx_drain

Receive-side buffer between the dual-channel laser receiver and the FTDI 245-style asynchronous FIFO on ADBUS. It captures each decoded byte pair on the rising edge of the receiver's `data_valid` and stores the pair in an internal FIFO. It then drains the FIFO to the host one byte at a time, data1 first, using a `wr_n` strobe sequence gated by the FTDI's `txe_n`. It runs on CLOCK_50 alongside the receivers and absorbs host back-pressure without stalling the optical link.

## Interface
- `DEPTH`, 16: FIFO depth in byte-pair entries; power of two, ≥2.
- `SETUP_CYC`, 1: cycles data is driven before `wr_n` falls; ≥1.
- `STROBE_CYC`, 3: cycles `wr_n` is held low; ≥1.
- `RECOVER_CYC`, 3: idle cycles after each byte before `txe_n` is re-examined; ≥1.

- `clock` in 1: system clock (CLOCK_50). Everything is on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `data_valid` in 1: receiver level output. A 0→1 transition marks a new pair.
- `data1_in` in 8: channel-1 (green) byte.
- `data2_in` in 8: channel-2 (IR) byte.
- `ftdi_txe_n` in 1: FTDI "transmit FIFO has space", active-low, asynchronous.
- `clear_overflow` in 1: synchronous clear of `overflow`.
- `ftdi_data` out 8: byte to ADBUS.
- `ftdi_oe` out 1: ADBUS output enable; the top drives ADBUS only while it is 1.
- `ftdi_wr_n` out 1: FTDI write strobe, active-low.
- `fifo_count` out $clog2(DEPTH)+1: occupied entries.
- `empty` out 1: `fifo_count == 0`.
- `overflow` out 1: sticky; a pair was dropped.

## Operation
- **Capture:** `dv_q` registers `data_valid`. A push occurs on an edge where `data_valid & ~dv_q`, and writes entry `{data1_in, data2_in}`.
- **Overflow:** on a push with count == DEPTH before the edge and no pop on the same edge:
  - the pair is dropped;
  - `overflow` is set to 1;
  - count is unchanged.
- **Push and pop on the same edge:** the push is accepted. When the FIFO is full this leaves count unchanged and `overflow` is not set.
- **Overflow priority:** if `clear_overflow` and a new drop occur on the same edge, `overflow` ends at 1.
- **Pointers:** read and write pointers wrap modulo DEPTH.
- **`txe_n` synchronizer:** `ftdi_txe_n` passes through a 2-flop synchronizer before use (`txe_s`).
- **Drain FSM states:** IDLE, SETUP, STROBE, HOLD, RECOVER. `byte_sel` is 0 for data1 and 1 for data2.
  - **IDLE:** `oe=0`, `wr_n=1`. Leave when `!empty & !txe_s`: load `ftdi_data` with the head byte selected by `byte_sel`, set `oe=1`, go to SETUP.
  - **SETUP:** hold for SETUP_CYC cycles, then STROBE.
  - **STROBE:** `wr_n=0` for STROBE_CYC cycles, then HOLD.
  - **HOLD:** `wr_n=1`, data still driven, for 1 cycle. On exit:
    - if `byte_sel==1`, pop the entry;
    - toggle `byte_sel`;
    - go to RECOVER.
  - **RECOVER:** `oe=0` for RECOVER_CYC cycles, then IDLE.
- **Commitment:** `txe_s` is examined only in IDLE. A write that has begun always completes, even if `txe_n` rises during it.
- **Byte order:** always data1 then data2 for each entry. Entries are never reordered or split across other entries.

## Timing
- **Reset values:**
  - `ftdi_wr_n=1`, `ftdi_oe=0`, `ftdi_data=8'h00`;
  - `fifo_count=0`, `empty=1`, `overflow=0`;
  - FSM in IDLE, `byte_sel=0`, `dv_q=0`.
  - Assertion of `reset_n` takes effect immediately and asynchronously, even mid-strobe. FIFO contents are discarded.
- **Push latency:** on push edge E0, `fifo_count`/`empty` update at E0.
- **First write:** with `txe_s` already low, the FSM enters SETUP at E1 and `wr_n` falls at E1+SETUP_CYC.
- **Byte period:** SETUP_CYC + STROBE_CYC + 1 + RECOVER_CYC + 1 (IDLE) cycles. This is 9 cycles at defaults, so a pair takes 18 cycles.
- **Pop timing:** the pop occurs on the HOLD→RECOVER edge of the second byte.
- **Back-pressure:** when `txe_n` deasserts, the FSM waits in IDLE. The response to a `txe_n` change lags by 2 cycles.
- **Sustained input:** `data_valid` held high produces only one push; a new push requires a return to 0.

## Configuration
- `LASER_RX_DRAIN_MARKER_EN`
  - **Defined:** each entry is emitted as three bytes: 8'hA5 marker, then data1, then data2. `byte_sel` becomes 2 bits (0→1→2) and the pop occurs after byte 2. Each byte uses the same per-byte sequence.
  - **Undefined:** two bytes per entry, no marker.

## Test plan
- **Single pair:** `txe_n=0`; pulse `data_valid` with data1=8'hC8, data2=8'h77.
  - Bytes: exactly two `wr_n` low pulses of 3 cycles each, with `ftdi_data` 8'hC8 then 8'h77 stable from SETUP through HOLD.
  - Latency: first `wr_n` fall 2 cycles after the push edge.
  - End state: `empty=1` after the second HOLD.
- **Back-pressure:** `txe_n=1`; push 3 pairs (12/34, 56/78, 9A/BC).
  - While blocked: `fifo_count=3`, `wr_n` stays 1.
  - On release (`txe_n=0`): 6 bytes out, in order 12,34,56,78,9A,BC.
- **Overflow:** `txe_n=1`; push DEPTH+2 pairs. `fifo_count=16`, `overflow=1`, and the first 16 pairs drain intact. Pulse `clear_overflow` → `overflow=0`.
- **Commit and level:**
  - Raise `txe_n` during STROBE of data1 → that byte completes, then the FSM waits in IDLE. Lower `txe_n` → data2 is sent.
  - Hold `data_valid` high for 50 cycles → exactly one push.
- **Reset mid-strobe:** assert `reset_n=0` while `wr_n=0` → same cycle `wr_n=1`, `oe=0`, `fifo_count=0`.
- **Marker variant:** with `LASER_RX_DRAIN_MARKER_EN`, a single pair 12/34 → bytes A5,12,34.
